ad9363_phy_emulator: RTL
========================

Name: ad9363_phy_emulator

Overview:
- Behavioural-synthesizable model of the AD9363 side of the 12-bit single-port CMOS data interface (1R1T, one word per clock).
- Receives the FPGA transmit stream (tx_frame/p1_d) and deframes it into I/Q samples. Buffers the samples in a FIFO and replays them as the receive stream (rx_frame/p0_d).
- Used as the far-end loopback partner for ad9363_stream in simulation and in on-board digital loopback builds.

Parameters:
- DEPTH_LOG2, 4, log2 of sample FIFO depth (DEPTH = 16 samples of 24 bits).
- DW, 12, bus/component width; fixed at 12 for AD9363.

Ports:
- clk  in  1  single clock; also serves as the interface data clock.
- rst  in  1  reset, asynchronous, active-low.
- tx_frame  in  1  1 = I word on p1_d, 0 = Q word.
- p1_d  in  12  transmit data word from FPGA.
- rx_frame  out  1  1 = I word on p0_d, 0 = Q word.
- p0_d  out  12  receive data word to FPGA.
- loop_en  in  1  1 = replay FIFO contents; 0 = transmit zeros, no pops.
- clr_flags  in  1  synchronous clear of sticky flags.
- overflow  out  1  sticky: sample dropped because FIFO full.
- underflow  out  1  sticky: I slot with empty FIFO while loop_en=1 and primed.
- frame_err  out  1  sticky: two consecutive I words seen.
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async): rx_frame=0, p0_d=0, all flags 0, fifo_level=0, FIFO pointers 0, deframer in WAIT_I, hold_q=0, primed=0.
- Deframer FSM, evaluated every clk:
  - WAIT_I: tx_frame=1 → latch I, go to GOT_I. tx_frame=0 → ignore word (leading Q discarded), stay.
  - GOT_I: tx_frame=0 → form sample {I,p1_d} (I in [23:12]), push, go to WAIT_I. tx_frame=1 → set frame_err, replace latched I with the new word, stay in GOT_I.
- FIFO push rules:
  - Push is accepted if fifo_level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - The first accepted push sets primed=1.
- Framer: all outputs are registered. rx_frame toggles on every clk edge after reset, free-running and independent of loop_en.
  - Edge with rx_frame currently 0 (next slot is I): if loop_en=1 and fifo_level≠0, pop the FIFO, p0_d<=head[23:12], hold_q<=head[11:0]. Otherwise p0_d<=0, hold_q<=0; in that case, if loop_en=1 and primed=1, set underflow.
  - Edge with rx_frame currently 1 (next slot is Q): p0_d<=hold_q.
- Latency: the empty check uses registered fifo_level. The I word appears on p0_d 2 cycles (phase aligned) or 3 cycles (phase misaligned) after the cycle in which its Q word is on p1_d.
- Simultaneous push and pop: fifo_level is unchanged; at full, both succeed.
- Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- clr_flags=1 clears overflow, underflow and frame_err on the next edge. A set condition in the same cycle wins.
- loop_en falling mid-sample: a sample already popped still completes its Q word. Subsequent slots carry zeros.
- rst asserted mid-operation: everything returns to reset values immediately; a partially received I is lost.

Test Plan:
- Reset, loop_en=1; drive (I,Q) = (0x123,0x456), (0x7FF,0x800), (0x001,0xFFF) back-to-back → p0_d yields the same pairs in order, rx_frame=1 on each I; overflow=0, underflow=0, frame_err=0.
- Drive 17 samples with loop_en=0 → fifo_level=16, overflow=1; set loop_en=1 → exactly the first 16 samples replay, then zeros with underflow=1.
- tx_frame high for two cycles (0x0AA then 0x0BB), then Q=0x0CC → frame_err=1; the replayed sample is (0x0BB,0x0CC).
- Leading Q word (tx_frame=0, 0x333) after reset → discarded; fifo_level stays 0 and primed stays 0, so underflow stays 0 with loop_en=1.
- FIFO full with continuous traffic at 1 sample per 2 cycles while replaying → level stays 16, overflow stays 0 (simultaneous push/pop accepted).
- Assert rst mid-stream, then assert clr_flags with flags set → all outputs return to 0 and rx_frame=0; flags cleared on the next edge.

Source files
------------

// File: rtl/ad9363_phy_emulator.sv
// AD9363-side model of the 12-bit single-port CMOS interface (1R1T).
// Deframes the FPGA transmit stream into I/Q samples, buffers them and
// replays them on the receive port as a digital loopback partner.
module ad9363_phy_emulator #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DW         = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_frame,
    input  logic [DW-1:0]         p1_d,
    output logic                  rx_frame,
    output logic [DW-1:0]         p0_d,
    input  logic                  loop_en,
    input  logic                  clr_flags,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  frame_err,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned SW    = 2 * DW;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic {
        WAIT_I = 1'b0,
        GOT_I  = 1'b1
    } defr_state_t;

    defr_state_t             r_state;
    logic [DW-1:0]           r_i;
    logic [SW-1:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wptr;
    logic [DEPTH_LOG2-1:0]   r_rptr;
    logic [LW-1:0]           r_level;
    logic                    r_primed;
    logic                    r_rx_frame;
    logic [DW-1:0]           r_p0_d;
    logic [DW-1:0]           r_hold_q;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    r_frame_err;

    logic                    w_push_req;
    logic                    w_push;
    logic                    w_pop;
    logic [SW-1:0]           w_head;
    logic                    w_ovf_set;
    logic                    w_ufl_set;
    logic                    w_ferr_set;

    // Pop only on an I-slot edge; the empty check uses the registered level
    assign w_pop      = loop_en && !r_rx_frame && (r_level != '0);
    assign w_push_req = (r_state == GOT_I) && !tx_frame;
    assign w_push     = w_push_req && ((r_level < LVL_FULL) || w_pop);
    assign w_head     = r_mem[r_rptr];
    assign w_ovf_set  = w_push_req && !w_push;
    assign w_ufl_set  = !r_rx_frame && !w_pop && loop_en && r_primed;
    assign w_ferr_set = (r_state == GOT_I) && tx_frame;

    // Deframer: pair an I word with the following Q word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_I;
            r_i     <= '0;
        end else begin
            case (r_state)
                WAIT_I: begin
                    if (tx_frame) begin
                        r_i     <= p1_d;
                        r_state <= GOT_I;
                    end
                end
                GOT_I: begin
                    if (tx_frame) begin
                        r_i <= p1_d;
                    end else begin
                        r_state <= WAIT_I;
                    end
                end
                default: r_state <= WAIT_I;
            endcase
        end
    end

    // Sample storage; contents need no reset since the level gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_i, p1_d};
        end
    end

    // FIFO pointers, occupancy and primed marker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_primed <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr   <= r_wptr + DEPTH_LOG2'(1);
                r_primed <= 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Framer: free-running I/Q slot toggle, Q half held from the popped sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_frame <= 1'b0;
            r_p0_d     <= '0;
            r_hold_q   <= '0;
        end else begin
            r_rx_frame <= !r_rx_frame;
            if (!r_rx_frame) begin
                if (w_pop) begin
                    r_p0_d   <= w_head[SW-1:DW];
                    r_hold_q <= w_head[DW-1:0];
                end else begin
                    r_p0_d   <= '0;
                    r_hold_q <= '0;
                end
            end else begin
                r_p0_d <= r_hold_q;
            end
        end
    end

    // Sticky flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set  || (r_overflow  && !clr_flags);
            r_underflow <= w_ufl_set  || (r_underflow && !clr_flags);
            r_frame_err <= w_ferr_set || (r_frame_err && !clr_flags);
        end
    end

    assign rx_frame   = r_rx_frame;
    assign p0_d       = r_p0_d;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign frame_err  = r_frame_err;
    assign fifo_level = r_level;

endmodule
